rv_front_pipe: RTL and testbench

Front-end pipeline register bank for the 5-stage RISC-V core: PC register (F), IF/ID register (D) and ID/EX register (E). It is the consumer of the hazard unit's StallF/StallD/FlushD/FlushE controls and of the E-stage redirect select PCSrcE. It applies them cycle-exactly so that stalls hold state, flushes insert architectural bubbles, and redirects steer fetch. Two saturating event counters expose stall and flush activity for performance debug.

---
 rtl/rv_front_pipe.sv | 96 +++++++++
 tb/tb_rv_front_pipe.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rv_front_pipe.sv
// rv_front_pipe: PC, IF/ID and ID/EX registers applying hazard stalls, flushes and redirects, with event counters.
module rv_front_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CTRL_W = 16,
  parameter int CNT_W = 16,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [1:0]        PCSrcE,
  input  logic [31:0]       PCTargetE,
  input  logic [31:0]       ALUResultE,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       ImmExtD,
  input  logic [CTRL_W-1:0] CtrlD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic              ValidE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       ImmExtE,
  output logic [31:0]       PCE,
  output logic [31:0]       PCPlus4E,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  assign pc_plus4 = PCF + 32'd4;
  // a redirect from E overrides a fetch stall; 11 behaves like 01
  always_comb
    pc_next = PCSrcE == 2'b10 ? ALUResultE :
              PCSrcE != 2'b00 ? PCTargetE :
              StallF          ? PCF : pc_plus4;
  always_ff @(posedge clk or posedge rst)
    if (rst) PCF <= RESET_PC;
    else PCF <= pc_next;
  always_ff @(posedge clk or posedge rst)
    if (rst || FlushD) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4;
      ValidD   <= 1'b1;
    end
  // a bubble carries x0 indices so it never matches a forwarding compare
  always_ff @(posedge clk or posedge rst)
    if (rst || FlushE) begin
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      CtrlE    <= '0;
      ValidE   <= 1'b0;
    end else begin
      Rs1E     <= InstrD[19:15];
      Rs2E     <= InstrD[24:20];
      RdE      <= InstrD[11:7];
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      CtrlE    <= CtrlD;
      ValidE   <= ValidD;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if ((StallF || StallD) && StallCnt != '1) StallCnt <= StallCnt + 1'b1;
      if ((FlushD || FlushE) && FlushCnt != '1) FlushCnt <= FlushCnt + 1'b1;
    end
endmodule

// File: tb/tb_rv_front_pipe.sv
// tb_rv_front_pipe: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_rv_front_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_f = 0, stall_d = 0, flush_d = 0, flush_e = 0;
  logic [1:0] pc_src = 0;
  logic [31:0] pc_target = 0, alu_result = 0;
  logic [31:0] instr_f, pcf, instr_d, pcd, pc_plus4_d, rd1_e, rd2_e, imm_e, pce, pc_plus4_e;
  logic valid_d, valid_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic [15:0] ctrl_e;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    string name;
    logic [9:0] m;
    logic [31:0] pcf, instrd, p4d, pce;
    logic vd, ve;
    logic [4:0] rde;
    logic [15:0] ctrle;
    logic [3:0] sc, fc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  // instruction memory: rd field is always 1, upper bits echo the fetch address
  assign instr_f = {pcf[19:0], 12'h083};

  rv_front_pipe #(.RESET_PC(32'h100), .CTRL_W(16), .CNT_W(4), .NOP(32'h13)) dut (
    .clk(clk), .rst(rst), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d), .FlushE(flush_e),
    .PCSrcE(pc_src), .PCTargetE(pc_target), .ALUResultE(alu_result), .InstrF(instr_f),
    .RD1D(32'h11), .RD2D(32'h22), .ImmExtD(32'h33), .CtrlD(16'hA5A5),
    .PCF(pcf), .InstrD(instr_d), .PCD(pcd), .PCPlus4D(pc_plus4_d), .ValidD(valid_d), .ValidE(valid_e),
    .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e), .RD1E(rd1_e), .RD2E(rd2_e), .ImmExtE(imm_e),
    .PCE(pce), .PCPlus4E(pc_plus4_e), .CtrlE(ctrl_e), .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
  );

  function automatic exp_t mk(string n, logic [31:0] pc, ins, p4, logic vd, ve,
                              logic [31:0] pe, logic [4:0] rd, logic [15:0] ct, logic [3:0] sc, fc);
    exp_t e;
    e.name = n; e.m = 10'h3FF; e.pcf = pc; e.instrd = ins; e.p4d = p4; e.vd = vd; e.ve = ve;
    e.pce = pe; e.rde = rd; e.ctrle = ct; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, req);
    end
  endtask

  // monitor: samples 1 time unit after each falling edge, or right after reset asserts
  always begin
    @(negedge clk or posedge rst);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) cmp(e.name, "PCF", pcf, e.pcf);
      if (e.m[1]) cmp(e.name, "InstrD", instr_d, e.instrd);
      if (e.m[2]) cmp(e.name, "PCPlus4D", pc_plus4_d, e.p4d);
      if (e.m[3]) cmp(e.name, "ValidD", {31'b0, valid_d}, {31'b0, e.vd});
      if (e.m[4]) cmp(e.name, "ValidE", {31'b0, valid_e}, {31'b0, e.ve});
      if (e.m[5]) cmp(e.name, "PCE", pce, e.pce);
      if (e.m[6]) cmp(e.name, "RdE", {27'b0, rd_e}, {27'b0, e.rde});
      if (e.m[7]) cmp(e.name, "CtrlE", {16'b0, ctrl_e}, {16'b0, e.ctrle});
      if (e.m[8]) cmp(e.name, "StallCnt", {28'b0, stall_cnt}, {28'b0, e.sc});
      if (e.m[9]) cmp(e.name, "FlushCnt", {28'b0, flush_cnt}, {28'b0, e.fc});
    end
  end

  task automatic drive(logic sf, sd, fd, fe, logic [1:0] src, logic [31:0] tgt, alu);
    @(negedge clk);
    #2;
    stall_f = sf; stall_d = sd; flush_d = fd; flush_e = fe;
    pc_src = src; pc_target = tgt; alu_result = alu;
  endtask

  initial begin
    exp_t e;
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    q.push_back(mk("reset", 32'h100, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 2'b00, 0, 0); rst = 1'b0;
    q.push_back(mk("edge1", 32'h104, 32'h00100083, 32'h104, 1, 0, 0, 0, 16'hA5A5, 0, 0));
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    q.push_back(mk("edge2", 32'h108, 32'h00104083, 32'h108, 1, 1, 32'h100, 1, 16'hA5A5, 0, 0));
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    q.push_back(mk("edge3", 32'h10C, 32'h00108083, 32'h10C, 1, 1, 32'h104, 1, 16'hA5A5, 0, 0));
    drive(1, 1, 0, 1, 2'b00, 0, 0);
    q.push_back(mk("load_use", 32'h10C, 32'h00108083, 32'h10C, 1, 0, 0, 0, 0, 1, 1));
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    q.push_back(mk("after_lu", 32'h110, 32'h0010C083, 32'h110, 1, 1, 32'h108, 1, 16'hA5A5, 1, 1));
    drive(0, 0, 1, 1, 2'b01, 32'h200, 32'h999);
    q.push_back(mk("branch", 32'h200, 32'h13, 0, 0, 0, 0, 0, 0, 1, 2));
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    q.push_back(mk("after_br", 32'h204, 32'h00200083, 32'h204, 1, 0, 0, 0, 16'hA5A5, 1, 2));
    drive(1, 0, 0, 0, 2'b10, 32'h888, 32'h3F0);
    q.push_back(mk("jalr_stall", 32'h3F0, 32'h00204083, 32'h208, 1, 1, 32'h200, 1, 16'hA5A5, 2, 2));
    drive(0, 0, 0, 0, 2'b11, 32'hFFFF_FFFC, 32'h500);
    q.push_back(mk("src11", 32'hFFFF_FFFC, 32'h003F0083, 32'h3F4, 1, 1, 32'h204, 1, 16'hA5A5, 2, 2));
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    q.push_back(mk("pc_wrap", 32'h0, 32'hFFFFC083, 32'h0, 1, 1, 32'h3F0, 1, 16'hA5A5, 2, 2));
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 2'b00, 0, 0);
      e = mk("sat", 32'h0, 0, 0, 0, 0, 0, 0, 0, (i + 3 > 15) ? 4'd15 : 4'(i + 3), 2);
      e.m = 10'h301;
      q.push_back(e);
    end
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    e = mk("sat_release", 32'h4, 0, 0, 0, 0, 0, 0, 0, 15, 2);
    e.m = 10'h301;
    q.push_back(e);
    drive(1, 0, 0, 0, 2'b01, 32'h700, 32'h0);
    q.push_back(mk("async_rst", 32'h100, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0); rst = 1'b0;
    q.push_back(mk("rst_rel1", 32'h104, 32'h00100083, 32'h104, 1, 0, 0, 0, 16'hA5A5, 0, 0));
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    q.push_back(mk("rst_rel2", 32'h108, 32'h00104083, 32'h108, 1, 1, 32'h100, 1, 16'hA5A5, 0, 0));
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
